// File: rtl/cmp_pkg.sv
// cmp_pkg -- shared definitions for the serial magnitude comparator.
//   NIBBLE_W     : digit width scanned per cycle (4 bits)
//   cmp_state_t  : FSM states IDLE / SCAN / DONE
//   cmp_result_t : latched decision {lt, eq, gt}, at most one bit set
package cmp_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_result_t;

  localparam cmp_result_t RES_NONE = '{lt: 1'b0, eq: 1'b0, gt: 1'b0};
  localparam cmp_result_t RES_LT   = '{lt: 1'b1, eq: 1'b0, gt: 1'b0};
  localparam cmp_result_t RES_EQ   = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};
  localparam cmp_result_t RES_GT   = '{lt: 1'b0, eq: 1'b0, gt: 1'b1};

endpackage

// File: rtl/nibble_mag_cmp.sv
// nibble_mag_cmp -- combinational 4-bit magnitude compare cell.
// Ports:
//   a, b : 4-bit digits to compare (unsigned)
//   gt   : a > b
//   lt   : a < b
//   eq   : a == b
// The decision is built as an MSB-first bit cascade: the first bit position
// where a and b differ decides, lower bits only matter while all higher bits
// are equal.
module nibble_mag_cmp
  import cmp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  output logic                gt,
  output logic                lt,
  output logic                eq
);

  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    for (int i = NIBBLE_W - 1; i >= 0; i--) begin
      // Only take a decision while no higher bit has decided yet.
      if (!gt && !lt) begin
        if (a[i] && !b[i]) gt = 1'b1;
        if (!a[i] && b[i]) lt = 1'b1;
      end
    end
    eq = !gt && !lt;
  end

endmodule

// File: rtl/serial_mag_cmp.sv
// serial_mag_cmp -- serial (nibble-per-cycle) magnitude comparator.
// Compares two WIDTH-bit operands MSB nibble first and stops at the first
// nibble that differs.
//
// Parameters:
//   WIDTH     : operand width, multiple of 4, at least 4 (default 32)
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : operand pair a/b/is_signed is valid
//   in_ready  : block can accept an operand pair (only while idle)
//   a, b      : operands
//   is_signed : compare as two's complement, sampled at accept
//   out_valid : lt/eq/gt hold a result
//   out_ready : consumer takes the result
//   lt/eq/gt  : A<B, A==B, A>B (exactly one high while out_valid)
// Build option:
//   SERIAL_MAG_CMP_SIGNED_EN : when defined, is_signed selects signed compare;
//                              when undefined, is_signed is ignored (unsigned).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer keeps its payload stable while valid is high and not yet
// accepted; ready never depends combinationally on valid. Input accept (IDLE)
// and output transfer (DONE) can never share a cycle, so after a result is
// taken the block spends one cycle in IDLE before the next accept.
module serial_mag_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int NIBS  = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  cmp_state_t       state;
  cmp_state_t       state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx;
  cmp_result_t      res_q;
  logic             n_gt;
  logic             n_lt;
  logic             n_eq;
  logic             last_nib;
  logic             sign_flip;

`ifdef SERIAL_MAG_CMP_SIGNED_EN
  assign sign_flip = is_signed;
`else
  // Port kept for a stable interface; unsigned compare only in this build.
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign sign_flip        = 1'b0;
`endif

  // Operand registers shift left each SCAN cycle, so the nibble under
  // inspection is always the top one; one compare cell serves every cycle.
  nibble_mag_cmp u_nib (
    .a  (a_q[WIDTH-1 -: NIBBLE_W]),
    .b  (b_q[WIDTH-1 -: NIBBLE_W]),
    .gt (n_gt),
    .lt (n_lt),
    .eq (n_eq)
  );

  assign last_nib = (idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)            state_nxt = SCAN;
      SCAN:    if (!n_eq || last_nib)   state_nxt = DONE;
      DONE:    if (out_ready)           state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode straight from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign lt = res_q.lt;
  assign eq = res_q.eq;
  assign gt = res_q.gt;

  // Datapath: operand capture, nibble walk and result latch.
  // Flipping the sign bit of both operands maps two's complement order onto
  // unsigned order, so the scan itself is identical in both modes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      res_q <= RES_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= sign_flip ? (a ^ MSB_MASK) : a;
            b_q   <= sign_flip ? (b ^ MSB_MASK) : b;
            idx   <= '0;
            res_q <= RES_NONE;
          end
        end
        SCAN: begin
          if (n_gt)          res_q <= RES_GT;
          else if (n_lt)     res_q <= RES_LT;
          else if (last_nib) res_q <= RES_EQ;
          else begin
            a_q <= a_q << NIBBLE_W;
            b_q <= b_q << NIBBLE_W;
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) res_q <= RES_NONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_cmp.sv
// tb_serial_mag_cmp -- self-checking bench for serial_mag_cmp (WIDTH=32).
// Directed cases (equal, MSB/LSB difference, backpressure, reset mid-scan)
// followed by a random regression. Expected results come from a native
// compare of the operands and are queued when stimulus is driven, then
// popped when out_valid appears.
module tb_serial_mag_cmp;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic         lt;
  logic         eq;
  logic         gt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [2:0] exp_q[$];
  int         lat_q[$];

  serial_mag_cmp #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference: {lt, eq, gt} from the language's own comparison operators.
  function automatic logic [2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic s);
    logic sgn;
`ifdef SERIAL_MAG_CMP_SIGNED_EN
    sgn = s;
`else
    sgn = 1'b0;
    if (s) sgn = 1'b0;
`endif
    if (sgn) return {$signed(x) < $signed(y), x == y, $signed(x) > $signed(y)};
    return {x < y, x == y, x > y};
  endfunction

  // Cycles from accept to out_valid: index of first differing nibble + 1,
  // or the nibble count when the operands are equal.
  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    d = x ^ y;
    for (int i = 0; i < W / 4; i++)
      if (d[W-1-4*i -: 4] != 4'h0) return i + 1;
    return W / 4;
  endfunction

  // ---------------- driver ----------------
  // Issues one pair, checks result/latency, optionally holds out_ready low
  // for 'hold' cycles while offering a second pair that must be ignored.
  task automatic do_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input int hold);
    logic [2:0] exp_r;
    logic [2:0] got;
    int         exp_l;
    int         acc;
    int         n;
    bit         seen;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      return;
    end
    a = ta; b = tb; is_signed = ts; in_valid = 1'b1; out_ready = (hold == 0);
    exp_q.push_back(model(ta, tb, ts));
    lat_q.push_back(exp_lat(ta, tb));
    @(negedge clk);
    acc = cyc;
    in_valid = 1'b0;
    // Scramble inputs after accept; the result in flight must not change.
    a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    exp_r = exp_q.pop_front();
    exp_l = lat_q.pop_front();
    if (!seen) begin
      check("out_valid_timeout", 32'd0, 32'd1);
      return;
    end
    got = {lt, eq, gt};
    check("result", 32'(got), 32'(exp_r));
    check("onehot", 32'($onehot(got)), 32'd1);
    check("latency", 32'(cyc - acc), 32'(exp_l));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom;
      @(negedge clk);
      check("bp_result", 32'({lt, eq, gt}), 32'(exp_r));
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Accept a=b=0, then hit reset part-way through the scan.
  task automatic reset_mid_scan();
    bit fired;
    a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    exp_q.push_back(model('0, '0, 1'b0));
    lat_q.push_back(exp_lat('0, '0));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async_out_valid", 32'(out_valid), 32'd0);
    check("rst_async_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    check("rst_release_in_ready", 32'(in_ready), 32'd1);
    fired = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) fired = 1'b1;
      @(negedge clk);
    end
    check("rst_no_result", 32'(fired), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           mode;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_lt_eq_gt", 32'({lt, eq, gt}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    do_cmp(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0);
    check("eq_deadbeef_exp", 32'(exp_lat(32'hDEADBEEF, 32'hDEADBEEF)), 32'd8);
    do_cmp(32'h80000000, 32'h7FFFFFFF, 1'b0, 0);
`ifdef SERIAL_MAG_CMP_SIGNED_EN
    do_cmp(32'h80000000, 32'h7FFFFFFF, 1'b1, 0);
`endif
    do_cmp(32'h00000001, 32'h00000002, 1'b0, 0);
    do_cmp(32'h12345678, 32'h12340000, 1'b0, 5);
    do_cmp(32'hFFFFFFFF, 32'h00000000, 1'b1, 0);
    reset_mid_scan();
    do_cmp(32'h0000000F, 32'h0000000F, 1'b0, 0);

    for (int i = 0; i < 10000; i++) begin
      x    = $urandom;
      mode = $urandom_range(0, 3);
      if (mode < 2)       y = x;
      else if (mode == 2) y = $urandom;
      else                y = x ^ (W'(1) << $urandom_range(0, W - 1));
      do_cmp(x, y, 1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
